// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants and grant/owner encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int BLOCK_LENGTH = 128;
    localparam int WORD_LENGTH  = 32;

    localparam logic GNT_DATA = 1'b0;
    localparam logic GNT_KEY  = 1'b1;

    localparam int PRIORITY_RR    = 0;
    localparam int PRIORITY_FIXED = 1;

endpackage
`default_nettype wire

// File: rtl/sub_bytes.sv
`default_nettype none
// ============================================================================
// Module      : sub_bytes
// Description : Combinational AES SubBytes, sixteen parallel forward S-boxes.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes (
    input  logic [127:0] i_data,
    output logic [127:0] o_data
);

    // Entry n lives at bits [(255-n)*8 +: 8], so the literal reads in table order.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        assign o_data[g*8 +: 8] = c_SBOX[(255 - int'(i_data[g*8 +: 8]))*8 +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/sbox_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sbox_share_arbiter
// Description : Shares one sub_bytes bank between the round datapath and the
//               key scheduler, with a single registered result stage.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_share_arbiter #(
    parameter int BLOCK_LENGTH  = 128,
    parameter int WORD_LENGTH   = 32,
    parameter int PRIORITY_MODE = 0,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic [BLOCK_LENGTH-1:0] d_req_data,
    output logic                    d_rsp_valid,
    input  logic                    d_rsp_ready,
    output logic [BLOCK_LENGTH-1:0] d_rsp_data,
    input  logic                    k_req_valid,
    output logic                    k_req_ready,
    input  logic [WORD_LENGTH-1:0]  k_req_word,
    output logic                    k_rsp_valid,
    input  logic                    k_rsp_ready,
    output logic [WORD_LENGTH-1:0]  k_rsp_word,
    output logic [CNT_WIDTH-1:0]    conflict_cnt
);

    import aes_pkg::*;

    logic                    r_full;
    logic                    r_owner;
    logic                    r_last_grant;
    logic [BLOCK_LENGTH-1:0] r_d_data;
    logic [WORD_LENGTH-1:0]  r_k_word;
    logic [CNT_WIDTH-1:0]    r_conflict_cnt;

    logic                    w_drain;
    logic                    w_can_accept;
    logic                    w_grant;
    logic                    w_accept;
    logic [BLOCK_LENGTH-1:0] w_sbox_in;
    logic [BLOCK_LENGTH-1:0] w_sbox_out;

    assign d_rsp_valid  = r_full && (r_owner == GNT_DATA);
    assign k_rsp_valid  = r_full && (r_owner == GNT_KEY);
    assign d_rsp_data   = r_d_data;
    assign k_rsp_word   = r_k_word;
    assign conflict_cnt = r_conflict_cnt;

    // Draining in the same cycle frees the stage, giving one result per cycle.
    assign w_drain      = (d_rsp_valid && d_rsp_ready) || (k_rsp_valid && k_rsp_ready);
    assign w_can_accept = !r_full || w_drain;

    always_comb begin
        w_grant = GNT_DATA;
        if (d_req_valid && k_req_valid) begin
            if (PRIORITY_MODE == PRIORITY_FIXED) w_grant = GNT_DATA;
            else                                 w_grant = ~r_last_grant;
        end else if (k_req_valid) begin
            w_grant = GNT_KEY;
        end
    end

    assign d_req_ready = w_can_accept && (w_grant == GNT_DATA);
    assign k_req_ready = w_can_accept && (w_grant == GNT_KEY);
    assign w_accept    = (d_req_valid && d_req_ready) || (k_req_valid && k_req_ready);

    assign w_sbox_in = (w_grant == GNT_KEY)
                     ? {{(BLOCK_LENGTH-WORD_LENGTH){1'b0}}, k_req_word}
                     : d_req_data;

    sub_bytes u_sub_bytes (
        .i_data (w_sbox_in),
        .o_data (w_sbox_out)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_full         <= 1'b0;
            r_owner        <= GNT_DATA;
            r_last_grant   <= GNT_KEY;
            r_d_data       <= '0;
            r_k_word       <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_full       <= 1'b1;
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                if (w_grant == GNT_DATA) r_d_data <= w_sbox_out;
                else                     r_k_word <= w_sbox_out[WORD_LENGTH-1:0];
            end else if (w_drain) begin
                r_full <= 1'b0;
            end
            if (d_req_valid && k_req_valid && w_can_accept &&
                (r_conflict_cnt != {CNT_WIDTH{1'b1}})) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
